// File: rtl/vedic_seq_mul16.sv
// vedic_seq_mul16: 16x16 unsigned multiplier that time-shares one external 8x8
// multiplier over four step cycles (LL, HL, LH, HH), accumulating partial
// products into a 32-bit accumulator and presenting the result under a
// valid/ready handshake.
module vedic_seq_mul16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p
);

    typedef enum logic [2:0] {
        StIdle,
        StLl,
        StHl,
        StLh,
        StHh,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] xr_q, xr_d;
    logic [15:0] yr_q, yr_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mul_p_ext;

    assign mul_p_ext = {16'h0000, mul_p};

    // Next-state, operand capture and partial-product accumulation.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = 32'h0000_0000;
                    state_d = StLl;
                end
            end
            StLl: begin
                acc_d   = acc_q + mul_p_ext;
                state_d = StHl;
            end
            StHl: begin
                acc_d   = acc_q + (mul_p_ext << 8);
                state_d = StLh;
            end
            StLh: begin
                acc_d   = acc_q + (mul_p_ext << 8);
                state_d = StHh;
            end
            StHh: begin
                // Sum of all four terms never exceeds 32 bits, so no carry-out.
                acc_d   = acc_q + (mul_p_ext << 16);
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand select for the shared 8x8 multiplier plus handshake outputs.
    always_comb begin
        mul_a     = 8'h00;
        mul_b     = 8'h00;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StLl: begin
                mul_a = xr_q[7:0];
                mul_b = yr_q[7:0];
            end
            StHl: begin
                mul_a = xr_q[15:8];
                mul_b = yr_q[7:0];
            end
            StLh: begin
                mul_a = xr_q[7:0];
                mul_b = yr_q[15:8];
            end
            StHh: begin
                mul_a = xr_q[15:8];
                mul_b = yr_q[15:8];
            end
            StDone: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // p mirrors the accumulator; it is only meaningful while out_valid is high.
    assign p = acc_q;

    // State register with synchronous reset that discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            xr_q    <= 16'h0000;
            yr_q    <= 16'h0000;
            acc_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_vedic_seq_mul16.sv
// Self-checking bench for vedic_seq_mul16. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A scoreboard queue holds
// expected products and a monitor pops one per completed output handshake.
module tb_vedic_seq_mul16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_pushed = 0;
    int unsigned n_popped = 0;
    logic [31:0] sb[$];
    logic        rnd_bp = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_p = 32'h0;

    // Behavioural stand-in for the external 8x8 multiplier.
    assign mul_p = 16'(mul_a) * 16'(mul_b);

    vedic_seq_mul16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks that p
    // holds steady while the consumer stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold && out_valid) begin
                chk("p_stable", p, prev_p);
            end
            if (out_valid && out_ready) begin
                n_popped++;
                if (sb.size() == 0) begin
                    chk("spurious_output", p, 32'hxxxx_xxxx);
                end else begin
                    chk("product", p, sb.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_p    = p;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Random backpressure, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expv);
        int n;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'h1);
        end
        sb.push_back(expv);
        n_pushed++;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(out_valid), 32'h1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 16'h0;
        y         = 16'h0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mul_a", 32'(mul_a), 32'h0);
        chk("rst_mul_b", 32'(mul_b), 32'h0);
        chk("rst_p", p, 32'h0);

        // 0x1234 * 0x5678 with operand sequence, then DONE one cycle after HH.
        step();
        send(16'h1234, 16'h5678, 32'h0626_0060);
        @(negedge clk);
        chk("seq_ll", {mul_a, mul_b}, 32'h3478);
        chk("seq_ll_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("seq_hl", {mul_a, mul_b}, 32'h1278);
        @(negedge clk);
        chk("seq_lh", {mul_a, mul_b}, 32'h3456);
        @(negedge clk);
        chk("seq_hh", {mul_a, mul_b}, 32'h1256);
        @(negedge clk);
        chk("done_valid", 32'(out_valid), 32'h1);
        chk("done_mul_ab", {mul_a, mul_b}, 32'h0);
        @(negedge clk);
        chk("idle_after_done", 32'(in_ready), 32'h1);

        // Corner operands.
        step();
        send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        send(16'h0000, 16'hABCD, 32'h0000_0000);
        send(16'h0100, 16'h0100, 32'h0001_0000);
        send(16'h00FF, 16'h0101, 32'h0000_FFFF);

        // Backpressure: hold out_ready low for 3 cycles in DONE.
        wait_valid("pre_bp_drain");
        step();
        out_ready = 1'b0;
        send(16'h8001, 16'h0003, 32'h0001_8003);
        wait_valid("bp_reach_done");
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("bp_valid_hold", 32'(out_valid), 32'h1);
            chk("bp_p_hold", p, 32'h0001_8003);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        chk("bp_release_busy", 32'(busy), 32'h0);

        // in_valid held with x/y churning while busy: only the first pair counts.
        step();
        send(16'h0011, 16'h0022, 32'h0000_0242);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = 16'(16'hA000 + i);
            y = 16'(16'h0B00 + i);
            @(negedge clk);
            chk("busy_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        @(negedge clk);
        chk("busy_done_valid", 32'(out_valid), 32'h1);
        send(16'h0030, 16'h0040, 32'h0000_0C00);

        // Reset pulsed during HL discards the operation.
        wait_valid("pre_rst_drain");
        step();
        x        = 16'h7777;
        y        = 16'h9999;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_in_hl", {mul_a, mul_b}, 32'h7799);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", 32'(out_valid), 32'h0);
        end
        step();
        send(16'h0002, 16'h0003, 32'h0000_0006);

        // Reset in DONE while stalled, together with in_valid: reset wins.
        wait_valid("pre_rst_done_drain");
        step();
        out_ready = 1'b0;
        x         = 16'h0005;
        y         = 16'h0005;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_done_reached", 32'(out_valid), 32'h1);
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_valid", 32'(out_valid), 32'h0);
        chk("rst_prio_busy", 32'(busy), 32'h0);

        // Random operands with random backpressure.
        step();
        rnd_bp = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, 32'(ra) * 32'(rb));
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("out_count", n_popped, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
